// File: rtl/timer_unit_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Register offsets, register-select codes, CTRL bit positions, mode codes,
// FSM state encoding and a small mode-decode helper.
package timer_unit_pkg;

    // CPU byte addresses of the three timer registers
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] ADDR_PRESET = 32'h0000_7F04;
    localparam logic [31:0] ADDR_COUNT  = 32'h0000_7F08;

    // Register select as seen on addr (CPU address bits [3:2])
    localparam logic [1:0] SEL_CTRL   = 2'b00;
    localparam logic [1:0] SEL_PRESET = 2'b01;
    localparam logic [1:0] SEL_COUNT  = 2'b10;

    // CTRL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // MODE codes; 1x decodes as one-shot
    localparam logic [1:0] MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

    // FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CNT  = 2'd2;
    localparam state_t ST_INT  = 2'd3;

    function automatic logic isAutoReload(input logic [1:0] mode);
        return mode == MODE_AUTORELOAD;
    endfunction

endpackage

// File: rtl/timer_unit_prescaler.sv
// Tick generator for the timer: one-cycle tick every DIV clocks.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - restart the divide sequence at 0 (asserted while the timer loads)
//   tick  - high for one cycle every DIV clocks
module timer_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] divCount;

    assign tick = (divCount == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            divCount <= '0;
        end else begin
            divCount <= divCount + CW'(1);
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable interrupt.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   we    - register write strobe
//   addr  - register select: 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 reserved
//   wd    - write data
//   rd    - read data, combinational from addr
//   irq   - interrupt request (pending & IM)
// Build option: define TIMER_PRESCALE_EN to count on prescaled ticks
// (every PRESCALE_DIV clocks) instead of every clock.
module timer_unit
    import timer_unit_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    logic [3:0]       ctrl;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    state_t           state;
    logic             pending;
    logic             tick;
    logic             en;
    logic             autoReload;

    if (PRESCALE_DIV < 2) begin : gDivCheck
        $error("PRESCALE_DIV must be >= 2");
    end

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .DIV(PRESCALE_DIV)
    ) uPrescaler (
        .clk  (clk),
        .reset(reset),
        .clear(state == ST_LOAD),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign en         = ctrl[CTRL_EN];
    assign autoReload = isAutoReload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign irq        = pending & ctrl[CTRL_IM];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            state   <= ST_IDLE;
            pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else begin
                            count   <= '0;
                            state   <= ST_INT;
                            pending <= 1'b1;
                        end
                    end
                end
                ST_INT: begin
                    if (autoReload) begin
                        pending <= 1'b0;
                        state   <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // CPU writes are placed last so they override the hardware EN
            // clear and the pending set/clear in the same cycle.
            if (we) begin
                case (addr)
                    SEL_CTRL: begin
                        ctrl    <= wd[3:0];
                        pending <= 1'b0;
                    end
                    SEL_PRESET: preset <= wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            SEL_CTRL:   rd[3:0] = ctrl;
            SEL_PRESET: rd      = preset;
            SEL_COUNT:  rd      = count;
            default:    rd      = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_unit.sv
module tb_timer_unit;
    import timer_unit_pkg::*;

`ifdef TIMER_PRESCALE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        chkCnt;
        logic        irq;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    timer_unit #(
        .WIDTH(32),
        .PRESCALE_DIV(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] a);
        addr = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        cyc();
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        we    = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        for (int a = 0; a < 4; a++) begin
            peek(2'(a));
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd addr=%0d: got %h exp %h", a, rd, 32'h0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b exp 0", irq);
        end
    endtask

    task automatic test_regs();
        doReset();
        wr(SEL_PRESET, 32'hA5A5_1234);
        wr(SEL_CTRL, 32'hFFFF_FFF0);
        wr(SEL_COUNT, 32'h0000_0055);
        wr(2'b11, 32'hFFFF_FFFF);
        peek(SEL_PRESET);
        checks++;
        if (rd !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL regs_preset: got %h exp %h", rd, 32'hA5A5_1234);
        end
        peek(SEL_CTRL);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL regs_ctrl_upper: got %h exp %h", rd, 32'h0);
        end
        peek(SEL_COUNT);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL regs_count_ro: got %h exp %h", rd, 32'h0);
        end
        peek(2'b11);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL regs_reserved: got %h exp %h", rd, 32'h0);
        end
    endtask

    task automatic test_oneshot();
        int n    = 5;
        int last = 2 + n * D;
        exp_t e;
        doReset();
        wr(SEL_PRESET, 32'(n));
        wr(SEL_CTRL, 32'h9);
        for (int k = 1; k <= last + 3; k++) begin
            e.chkCnt = 1'b1;
            if (k < 2)         e.cnt = 32'h0;
            else if (k < last) e.cnt = 32'(n - (k - 2) / D);
            else               e.cnt = 32'h0;
            e.irq = (k >= last);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            cyc();
            peek(SEL_COUNT);
            e = sb.pop_front();
            checks++;
            if (rd !== e.cnt) begin
                errors++;
                $display("FAIL oneshot_count: got %h exp %h", rd, e.cnt);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL oneshot_irq: got %b exp %b", irq, e.irq);
            end
        end
        peek(SEL_CTRL);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_en_clear: got %h exp %h", rd, 32'h8);
        end
        wr(SEL_CTRL, 32'h0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_ack: got %b exp 0", irq);
        end
    endtask

    task automatic test_autoreload(input int n, input int periods);
        int p = 2 + n * D;
        exp_t e;
        doReset();
        wr(SEL_PRESET, 32'(n));
        wr(SEL_CTRL, 32'hB);
        for (int k = 1; k <= 2 + periods * p; k++) begin
            e.irq    = (k % p == 0);
            e.chkCnt = 1'b0;
            e.cnt    = 32'h0;
            if (k == 2 || (k > 2 && (k - 2) % p == 0)) begin
                e.chkCnt = 1'b1;
                e.cnt    = 32'(n);
            end else if (k % p == 0) begin
                e.chkCnt = 1'b1;
            end
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            cyc();
            peek(SEL_COUNT);
            e = sb.pop_front();
            if (e.chkCnt) begin
                checks++;
                if (rd !== e.cnt) begin
                    errors++;
                    $display("FAIL auto_count n=%0d: got %h exp %h", n, rd, e.cnt);
                end
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL auto_irq n=%0d: got %b exp %b", n, irq, e.irq);
            end
        end
    endtask

    task automatic test_mask();
        int last = 2 + 10 * D;
        exp_t e;
        doReset();
        wr(SEL_PRESET, 32'd10);
        wr(SEL_CTRL, 32'h1);
        for (int k = 1; k <= last + 3; k++) begin
            e.irq    = 1'b0;
            e.chkCnt = (k >= last);
            e.cnt    = 32'h0;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            cyc();
            peek(SEL_COUNT);
            e = sb.pop_front();
            if (e.chkCnt) begin
                checks++;
                if (rd !== e.cnt) begin
                    errors++;
                    $display("FAIL mask_count: got %h exp %h", rd, e.cnt);
                end
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL mask_irq: got %b exp %b", irq, e.irq);
            end
        end
        peek(SEL_CTRL);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mask_en_clear: got %h exp %h", rd, 32'h0);
        end
        wr(SEL_CTRL, 32'h8);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL mask_pending_clear: got %b exp 0", irq);
            end
            cyc();
        end
    endtask

    task automatic test_midcount();
        exp_t e;
        doReset();
        wr(SEL_PRESET, 32'd8);
        wr(SEL_CTRL, 32'h1);
        repeat (1 + 4 * D) cyc();
        peek(SEL_COUNT);
        checks++;
        if (rd !== 32'd5) begin
            errors++;
            $display("FAIL mid_before: got %h exp %h", rd, 32'd5);
        end
        wr(SEL_CTRL, 32'h0);
        for (int k = 0; k < 5; k++) begin
            e.cnt = 32'd4; e.chkCnt = 1'b1; e.irq = 1'b0;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            peek(SEL_COUNT);
            e = sb.pop_front();
            checks++;
            if (rd !== e.cnt) begin
                errors++;
                $display("FAIL mid_frozen: got %h exp %h", rd, e.cnt);
            end
            cyc();
        end
        wr(SEL_PRESET, 32'd2);
        wr(SEL_CTRL, 32'h9);
        for (int k = 1; k <= 3 + 2 * D; k++) begin
            e.chkCnt = (k == 2);
            e.cnt    = 32'd2;
            e.irq    = (k >= 2 + 2 * D);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            cyc();
            peek(SEL_COUNT);
            e = sb.pop_front();
            if (e.chkCnt) begin
                checks++;
                if (rd !== e.cnt) begin
                    errors++;
                    $display("FAIL mid_reload: got %h exp %h", rd, e.cnt);
                end
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL mid_irq: got %b exp %b", irq, e.irq);
            end
        end
    endtask

    task automatic test_collision();
        int last = 2 + 3 * D;
        exp_t e;
        doReset();
        wr(SEL_PRESET, 32'd3);
        wr(SEL_CTRL, 32'h9);
        repeat (last) cyc();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL coll_irq_rise: got %b exp 1", irq);
        end
        wr(SEL_CTRL, 32'h9);
        peek(SEL_CTRL);
        checks++;
        if (rd !== 32'h9) begin
            errors++;
            $display("FAIL coll_cpu_wins: got %h exp %h", rd, 32'h9);
        end
        for (int k = 0; k <= last; k++) begin
            e.chkCnt = 1'b0;
            e.cnt    = 32'h0;
            e.irq    = (k == last);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL coll_irq: got %b exp %b", irq, e.irq);
            end
            cyc();
        end
    endtask

    task automatic test_reset_midcount();
        logic seenIrq = 1'b0;
        logic found   = 1'b0;
        doReset();
        wr(SEL_PRESET, 32'd3);
        wr(SEL_CTRL, 32'hB);
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            peek(SEL_COUNT);
            if (seenIrq && rd == 32'd3) found = 1'b1;
            if (irq) seenIrq = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_timeout: got no reload exp COUNT=3");
        end
        doReset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 4; a++) begin
                peek(2'(a));
                checks++;
                if (rd !== 32'h0) begin
                    errors++;
                    $display("FAIL rstmid_rd addr=%0d: got %h exp %h", a, rd, 32'h0);
                end
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_irq: got %b exp 0", irq);
            end
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wd    = '0;
        test_reset();
        test_regs();
        test_oneshot();
        test_autoreload(3, 4);
`ifdef TIMER_PRESCALE_EN
        test_autoreload(2, 3);
`endif
        test_mask();
        test_midcount();
        test_collision();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
